mem_access_stage: RTL and testbench

Pipeline MEM stage: produces the write-back operands consumed by the write-back select.
- Accepts one instruction per cycle from EX/MEM.
- Runs loads/stores to data memory over a req/ack handshake, stalling upstream while waiting.
- Registers the MEM/WB fields: ALU result `wr`, load data `wdo`, select `wm2reg`, destination `wrn`, write enable `wwreg`.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_wb_reg.sv | 32 +++
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MEM pipeline stage:
//   state_t      - MEM-stage FSM states (IDLE, ACCESS)
//   REG_NUM_W    - register-number width
//   WORD_W       - data word width
//   wb_fields_t  - MEM/WB pipeline register contents {wwreg, wm2reg, wrn, wr, wdo}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_NUM_W = 5;
    localparam int WORD_W    = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                 wwreg;
        logic                 wm2reg;
        logic [REG_NUM_W-1:0] wrn;
        logic [WORD_W-1:0]    wr;
        logic [WORD_W-1:0]    wdo;
    } wb_fields_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory req/ack bus between the MEM stage and data memory.
//   dmem_req   : request, held until ack          (master -> slave)
//   dmem_we    : 1 = store, 0 = load              (master -> slave)
//   dmem_addr  : word-aligned byte address        (master -> slave)
//   dmem_wdata : store data                       (master -> slave)
//   dmem_ack   : request complete, rdata valid    (slave  -> master)
//   dmem_rdata : load data                        (slave  -> master)
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register: loads i_fields when i_load is high, otherwise holds.
//   clock    : rising-edge clock
//   resetn   : asynchronous active-low clear
//   i_load   : load enable
//   i_fields : next write-back fields
//   o_fields : registered write-back fields
// -----------------------------------------------------------------------------
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_load,
    input  wb_fields_t i_fields,
    output wb_fields_t o_fields
);

    wb_fields_t r_fields;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fields <= '0;
        end else if (i_load) begin
            r_fields <= i_fields;
        end
    end

    assign o_fields = r_fields;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Pipeline MEM stage. ALU ops pass straight into the MEM/WB register in one
// cycle; loads/stores run a req/ack transaction to data memory while the
// stage stalls upstream (in_ready low), then update the MEM/WB register.
//
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   in_valid / in_ready    : EX/MEM handshake
//   mwreg, mm2reg, mwmem   : reg-write, load, store controls
//   mrn, malu, mb          : dest reg, ALU result / address, store data
//   dmem (master modport)  : data-memory req/ack bus
//   wvalid                 : one-cycle pulse, MEM/WB fields updated
//   wwreg, wm2reg, wrn,
//   wr, wdo                : MEM/WB fields
//   misalign               : misaligned-access pulse
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   - memory ops with malu[1:0] != 0 complete at once without a
//               request, with wwreg=0 and a misalign pulse
//   undefined - low address bits ignored, misalign tied 0
// -----------------------------------------------------------------------------
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mwreg,
    input  logic                 mm2reg,
    input  logic                 mwmem,
    input  logic [REG_NUM_W-1:0] mrn,
    input  logic [DATA_W-1:0]    malu,
    input  logic [DATA_W-1:0]    mb,
    mem_access_stage_if.master   dmem,
    output logic                 wvalid,
    output logic                 wwreg,
    output logic                 wm2reg,
    output logic [REG_NUM_W-1:0] wrn,
    output logic [DATA_W-1:0]    wr,
    output logic [DATA_W-1:0]    wdo,
    output logic                 misalign
);

    state_t               r_state;
    state_t               w_state_next;

    // Memory op captured at issue; held stable for the whole ACCESS phase.
    logic                 r_we;
    logic                 r_load;
    logic                 r_wreg;
    logic [REG_NUM_W-1:0] r_rn;
    logic [DATA_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_wvalid;

    logic                 w_accept;
    logic                 w_memop;
    logic                 w_misal;
    logic                 w_issue;
    logic                 w_done;
    logic                 w_wb_load;
    wb_fields_t           w_wb_next;
    wb_fields_t           w_wb_q;

    assign w_accept = in_valid & in_ready;
    assign w_memop  = mm2reg | mwmem;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misal = w_memop & (malu[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    // A misaligned memory op is retired like an ALU op, so only aligned
    // memory ops start a memory transaction.
    assign w_issue   = w_accept & w_memop & ~w_misal;
    assign w_done    = (r_state == ACCESS) & dmem.dmem_ack;
    assign w_wb_load = (w_accept & ~w_issue) | w_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_state_next = ACCESS;
            ACCESS:  if (dmem.dmem_ack) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state register only) ----------------
    always_comb begin
        dmem.dmem_req = 1'b0;
        in_ready      = 1'b0;
        case (r_state)
            IDLE:    in_ready      = 1'b1;
            ACCESS:  dmem.dmem_req = 1'b1;
            default: in_ready      = 1'b0;
        endcase
    end

    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata = r_wdata;

    // ---------------- capture of the memory op ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_load  <= 1'b0;
            r_wreg  <= 1'b0;
            r_rn    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_issue) begin
            r_we    <= mwmem;
            // Both load and store set: the store wins.
            r_load  <= mm2reg & ~mwmem;
            r_wreg  <= mwreg;
            r_rn    <= mrn;
            r_addr  <= malu;
            r_wdata <= mb;
        end
    end

    // ---------------- next MEM/WB fields ----------------
    always_comb begin
        w_wb_next = w_wb_q;
        if (r_state == ACCESS) begin
            w_wb_next.wwreg  = r_wreg;
            w_wb_next.wm2reg = r_load;
            w_wb_next.wrn    = r_rn;
            w_wb_next.wr     = r_addr;
            if (r_load) begin
                w_wb_next.wdo = dmem.dmem_rdata;
            end
        end else begin
            w_wb_next.wwreg  = mwreg & ~w_misal;
            w_wb_next.wm2reg = 1'b0;
            w_wb_next.wrn    = mrn;
            w_wb_next.wr     = malu;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clock    (clock),
        .resetn   (resetn),
        .i_load   (w_wb_load),
        .i_fields (w_wb_next),
        .o_fields (w_wb_q)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wvalid <= 1'b0;
        end else begin
            r_wvalid <= w_wb_load;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_misalign;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept & w_misal;
        end
    end
    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    assign wvalid = r_wvalid;
    assign wwreg  = w_wb_q.wwreg;
    assign wm2reg = w_wb_q.wm2reg;
    assign wrn    = w_wb_q.wrn;
    assign wr     = w_wb_q.wr;
    assign wdo    = w_wb_q.wdo;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench: directed cases followed by random instruction streams.
// The bench plays data memory, choosing ack latency and load data, and keeps
// the expected MEM/WB contents as plain variables updated per instruction.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic [31:0] mb;
    logic        wvalid;
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrn;
    logic [31:0] wr;
    logic [31:0] wdo;
    logic        misalign;

    mem_access_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem ();

    mem_access_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mrn      (mrn),
        .malu     (malu),
        .mb       (mb),
        .dmem     (dmem.master),
        .wvalid   (wvalid),
        .wwreg    (wwreg),
        .wm2reg   (wm2reg),
        .wrn      (wrn),
        .wr       (wr),
        .wdo      (wdo),
        .misalign (misalign)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Expected MEM/WB contents
    logic        e_wwreg;
    logic        e_wm2reg;
    logic [4:0]  e_wrn;
    logic [31:0] e_wr;
    logic [31:0] e_wdo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        e_wwreg  = 1'b0;
        e_wm2reg = 1'b0;
        e_wrn    = '0;
        e_wr     = '0;
        e_wdo    = '0;
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".wwreg"},  64'(wwreg),  64'(e_wwreg));
        check({tag, ".wm2reg"}, 64'(wm2reg), 64'(e_wm2reg));
        check({tag, ".wrn"},    64'(wrn),    64'(e_wrn));
        check({tag, ".wr"},     64'(wr),     64'(e_wr));
        check({tag, ".wdo"},    64'(wdo),    64'(e_wdo));
    endtask

    // Upstream junk while the stage is not accepting (or in_valid is low).
    task automatic scramble_inputs(input bit allow_valid);
        in_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        mwreg    = 1'($urandom_range(0, 1));
        mm2reg   = 1'($urandom_range(0, 1));
        mwmem    = 1'($urandom_range(0, 1));
        mrn      = 5'($urandom);
        malu     = $urandom;
        mb       = $urandom;
    endtask

    // Idle cycle with no instruction; a stray ack must be ignored.
    task automatic idle_cycle(input bit stray_ack);
        scramble_inputs(1'b0);
        dmem.dmem_ack   = stray_ack;
        dmem.dmem_rdata = $urandom;
        tick();
        dmem.dmem_ack = 1'b0;
        check("idle.wvalid",   64'(wvalid),        64'(0));
        check("idle.misalign", 64'(misalign),      64'(0));
        check("idle.dmem_req", 64'(dmem.dmem_req), 64'(0));
        check("idle.in_ready", 64'(in_ready),      64'(1));
        check_fields("idle");
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 load+store (behaves as store)
    task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] rn, input bit wreg, input int k,
                             input logic [31:0] rdata);
        bit is_mem;
        bit is_load;
        bit is_misal;
        is_mem  = (kind != 0);
        is_load = (kind == 1);
        is_misal = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        is_misal = is_mem && (addr[1:0] != 2'b00);
`endif
        check("pre.in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        mwreg    = wreg;
        mm2reg   = (kind == 1) || (kind == 3);
        mwmem    = (kind == 2) || (kind == 3);
        mrn      = rn;
        malu     = addr;
        mb       = data;
        tick();
        if (!is_mem || is_misal) begin
            e_wwreg  = is_misal ? 1'b0 : wreg;
            e_wm2reg = 1'b0;
            e_wrn    = rn;
            e_wr     = addr;
            check("alu.wvalid",   64'(wvalid),        64'(1));
            check("alu.misalign", 64'(misalign),      64'(is_misal));
            check("alu.dmem_req", 64'(dmem.dmem_req), 64'(0));
            check_fields("alu");
            $display("txn kind=%0d addr=%08h rn=%0d wreg=%0d misal=%0d -> wr=%08h wrn=%0d wwreg=%0d",
                     kind, addr, rn, wreg, is_misal, wr, wrn, wwreg);
        end else begin
            check("acc.wvalid0", 64'(wvalid), 64'(0));
            for (int i = 1; i <= k; i++) begin
                check("acc.dmem_req",   64'(dmem.dmem_req),   64'(1));
                check("acc.in_ready",   64'(in_ready),        64'(0));
                check("acc.dmem_we",    64'(dmem.dmem_we),    64'(kind >= 2));
                check("acc.dmem_addr",  64'(dmem.dmem_addr),  64'({addr[31:2], 2'b00}));
                check("acc.dmem_wdata", 64'(dmem.dmem_wdata), 64'(data));
                scramble_inputs(1'b1);
                if (i == k) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = rdata;
                end else begin
                    dmem.dmem_ack   = 1'b0;
                    dmem.dmem_rdata = $urandom;
                end
                tick();
                dmem.dmem_ack = 1'b0;
                in_valid      = 1'b0;
                if (i < k) begin
                    check("acc.wvalid_wait", 64'(wvalid), 64'(0));
                    check_fields("acc.hold");
                end
            end
            e_wwreg  = wreg;
            e_wm2reg = is_load;
            e_wrn    = rn;
            e_wr     = addr;
            if (is_load) e_wdo = rdata;
            check("mem.wvalid",   64'(wvalid),        64'(1));
            check("mem.dmem_req", 64'(dmem.dmem_req), 64'(0));
            check("mem.in_ready", 64'(in_ready),      64'(1));
            check_fields("mem");
            $display("txn kind=%0d addr=%08h data=%08h rn=%0d wreg=%0d k=%0d -> wr=%08h wdo=%08h wm2reg=%0d",
                     kind, addr, data, rn, wreg, k, wr, wdo, wm2reg);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        resetn          = 1'b0;
        in_valid        = 1'b0;
        mwreg           = 1'b0;
        mm2reg          = 1'b0;
        mwmem           = 1'b0;
        mrn             = '0;
        malu            = '0;
        mb              = '0;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        model_clear();

        // Reset
        tick();
        tick();
        check("rst.wvalid",   64'(wvalid),        64'(0));
        check("rst.misalign", 64'(misalign),      64'(0));
        check("rst.dmem_req", 64'(dmem.dmem_req), 64'(0));
        check_fields("rst");
        resetn = 1'b1;
        tick();
        check("rst.in_ready", 64'(in_ready),      64'(1));
        check("rst.wvalid1",  64'(wvalid),        64'(0));
        $display("txn reset released");

        // Back-to-back ALU ops
        run_instr(0, 32'h10, 32'h0, 5'd3, 1'b1, 1, 32'h0);
        run_instr(0, 32'h20, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        idle_cycle(1'b0);

        // Load with ack after 3 cycles
        run_instr(1, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF);
        // Store acked in its first ACCESS cycle
        run_instr(2, 32'h104, 32'h55AA, 5'd9, 1'b0, 1, 32'h12345678);
        idle_cycle(1'b1);
        // Load+store treated as store
        run_instr(3, 32'h108, 32'hA5A5, 5'd2, 1'b1, 2, 32'hCAFEF00D);

`ifdef LSU_MISALIGN_CHECK_EN
        run_instr(1, 32'h102, 32'h0, 5'd5, 1'b1, 1, 32'h0);
        idle_cycle(1'b0);
`endif

        // Reset in the middle of an ACCESS, then a late ack
        in_valid = 1'b1;
        mwreg    = 1'b1;
        mm2reg   = 1'b1;
        mwmem    = 1'b0;
        mrn      = 5'd11;
        malu     = 32'h200;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid.dmem_req_pre", 64'(dmem.dmem_req), 64'(1));
        resetn = 1'b0;
        #1;
        model_clear();
        check("mid.dmem_req", 64'(dmem.dmem_req), 64'(0));
        check("mid.wvalid",   64'(wvalid),        64'(0));
        check_fields("mid");
        tick();
        resetn          = 1'b1;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hBAADF00D;
        tick();
        dmem.dmem_ack = 1'b0;
        check("late.wvalid",   64'(wvalid),        64'(0));
        check("late.dmem_req", 64'(dmem.dmem_req), 64'(0));
        check("late.in_ready", 64'(in_ready),      64'(1));
        check_fields("late");
        $display("txn reset mid-access, late ack ignored");

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            int kind;
            int gap;
            kind = $urandom_range(0, 3);
            run_instr(kind, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), $urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
